// File: rtl/mmio_timer.sv
// Memory-mapped 32-bit timer: prescaled up-counter, compare match,
// wrap flag and level interrupt on a simple sel/we/re register bus.
module mmio_timer #(
    parameter int          PRESCALE_W  = 16,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        irq,
    output logic        tick
);

    logic [2:0]            r_ctrl;
    logic [PRESCALE_W-1:0] r_pre;
    logic [PRESCALE_W-1:0] r_pcnt;
    logic [31:0]           r_count;
    logic [31:0]           r_cmp;
    logic                  r_match;
    logic                  r_wrap;

    logic        w_mapped;
    logic        w_wr;
    logic        w_sel_ctrl;
    logic        w_sel_pre;
    logic        w_sel_cnt;
    logic        w_sel_cmp;
    logic        w_sel_stat;
    logic [31:0] w_mask;
    logic [31:0] w_ctrl_m;
    logic [31:0] w_pre_m;
    logic [31:0] w_cmp_m;
    logic [31:0] w_cnt_m;
    logic [2:0]  w_ctrl_nxt;
    logic        w_cmp_hit;
    logic        w_set_match;
    logic        w_set_wrap;
    logic [31:0] w_cnt_hw;
    logic [1:0]  w_clr;

    assign w_mapped   = (addr[7:5] == 3'd0) && (addr[4:2] <= 3'd4);
    assign w_wr       = sel && we && w_mapped;
    assign w_sel_ctrl = addr[4:2] == 3'd0;
    assign w_sel_pre  = addr[4:2] == 3'd1;
    assign w_sel_cnt  = addr[4:2] == 3'd2;
    assign w_sel_cmp  = addr[4:2] == 3'd3;
    assign w_sel_stat = addr[4:2] == 3'd4;

    assign w_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    assign w_ctrl_m = ({29'd0, r_ctrl} & ~w_mask) | (wdata & w_mask);
    assign w_pre_m  = (32'(r_pre) & ~w_mask) | (wdata & w_mask);
    assign w_cmp_m  = (r_cmp & ~w_mask) | (wdata & w_mask);

    assign w_ctrl_nxt = (w_wr && w_sel_ctrl) ? w_ctrl_m[2:0] : r_ctrl;

    assign tick = r_ctrl[0] && (r_pcnt == r_pre);
    assign irq  = r_match && r_ctrl[2];

    // Compare has priority over the all-ones wrap; reload suppresses wrap.
    assign w_cmp_hit   = r_count == r_cmp;
    assign w_set_match = tick && w_cmp_hit;
    assign w_set_wrap  = tick && (&r_count) && !(w_cmp_hit && r_ctrl[1]);

    always_comb begin
        w_cnt_hw = r_count;
        if (tick) begin
            if (w_cmp_hit && r_ctrl[1]) w_cnt_hw = 32'd0;
            else                        w_cnt_hw = r_count + 32'd1;
        end
    end

    assign w_cnt_m = (w_cnt_hw & ~w_mask) | (wdata & w_mask);
    assign w_clr   = (w_wr && w_sel_stat && be[0]) ? wdata[1:0] : 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl  <= 3'd0;
            r_pre   <= '0;
            r_pcnt  <= '0;
            r_count <= 32'd0;
            r_cmp   <= COMPARE_RST;
            r_match <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_ctrl <= w_ctrl_nxt;
            if (w_wr && w_sel_pre) r_pre <= w_pre_m[PRESCALE_W-1:0];
            if (w_wr && w_sel_cmp) r_cmp <= w_cmp_m;
            r_count <= (w_wr && w_sel_cnt) ? w_cnt_m : w_cnt_hw;
            if (!r_ctrl[0] || !w_ctrl_nxt[0] || tick) r_pcnt <= '0;
            else r_pcnt <= r_pcnt + PRESCALE_W'(1);
            r_match <= (r_match && !w_clr[0]) || w_set_match;
            r_wrap  <= (r_wrap && !w_clr[1]) || w_set_wrap;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (sel && re && w_mapped) begin
            unique case (1'b1)
                w_sel_ctrl: rdata = {29'd0, r_ctrl};
                w_sel_pre:  rdata = 32'(r_pre);
                w_sel_cnt:  rdata = r_count;
                w_sel_cmp:  rdata = r_cmp;
                w_sel_stat: rdata = {30'd0, r_wrap, r_match};
                default:    rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped 32-bit timer/compare peripheral. It is the responder on the core's data-memory bus; the core is the initiator.
- Instantiated in the SoC at 0x0003_0000. The top-level decoder drives `sel`, and `rdata` feeds the SoC data read mux alongside GPIO and data SRAM.
- Provides a prescaled up-counter, a compare-match flag with optional auto-reload, a wrap-around flag, and a level interrupt output.

Parameters:
- PRESCALE_W, 16, width of the PRESCALE register and of the internal prescale counter.
- COMPARE_RST, 32'hFFFF_FFFF, reset value of the COMPARE register.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- sel  input  1  peripheral selected (address decode hit from the top level).
- addr  input  8  byte offset within the peripheral; addr[1:0] ignored.
- wdata  input  32  write data.
- be  input  4  byte enables for writes; be[n] covers wdata[8n+7:8n].
- we  input  1  write strobe; qualified by sel.
- re  input  1  read strobe; qualified by sel.
- rdata  output  32  read data, combinational, same cycle.
- irq  output  1  level interrupt = STATUS.match & CTRL.irq_en.
- tick  output  1  single-cycle pulse on each prescaled count event.

Behaviour:
- Register map, decoded by addr[4:2]. Any offset with addr[7:5]!=0 or addr[4:2]>4 is unmapped.
  - 0x00 CTRL, RW: bit0 en, bit1 autoreload, bit2 irq_en; other bits read 0.
  - 0x04 PRESCALE, RW: bits [PRESCALE_W-1:0]; upper bits read 0.
  - 0x08 COUNT, RW, 32 bits.
  - 0x0C COMPARE, RW, 32 bits.
  - 0x10 STATUS: bit0 match, bit1 wrap. Write-1-to-clear per bit, honouring be[0].
- Reset values: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=COMPARE_RST, STATUS=0, prescale counter=0. Outputs irq=0, tick=0, rdata=0.
- Reads:
  - rdata = selected register when sel & re & mapped; otherwise 0.
  - Reads have no side effects, and STATUS is not clear-on-read.
- Writes:
  - Occur at the clk edge when sel & we & mapped; each byte is updated only where its be bit is set.
  - Unmapped writes are ignored.
- Prescaler:
  - When en=0, the prescale counter is held at 0 and tick=0.
  - When en=1, the prescale counter increments each cycle. When it equals PRESCALE it returns to 0 and tick is asserted for that cycle.
  - Tick period is therefore PRESCALE+1 cycles; PRESCALE=0 gives a tick every cycle.
  - The first tick after en rises occurs PRESCALE+1 cycles after the write.
- Count update on tick (evaluated against the current COUNT):
  - If COUNT==COMPARE: set match. COUNT becomes 0 when autoreload=1, otherwise COUNT+1.
  - Else if COUNT==32'hFFFF_FFFF: COUNT becomes 0 and wrap is set.
  - Otherwise COUNT becomes COUNT+1.
  - Match and wrap on the same tick are both set: COMPARE=FFFF_FFFF with autoreload=0 wraps to 0.
- Simultaneous events:
  - Bus write to COUNT in a tick cycle: the written bytes win; unwritten bytes take the tick-updated value.
  - W1C on STATUS in the same cycle as a hardware set of that bit: the set wins (flag stays 1).
  - Write to PRESCALE: takes effect immediately; the prescale counter is not reset. If the counter already exceeds the new PRESCALE, it counts up and wraps at 2^PRESCALE_W.
  - Writing en=0: freezes COUNT and clears the prescale counter.
- irq is registered-equivalent: it derives from flops only, with no combinational path from bus inputs.
- Asynchronous reset mid-count returns all state to reset values immediately.
- Reset deassertion is assumed synchronised at the SoC level; the block adds no synchroniser.

Test Plan:
- Reset check: after reset, read 0x0C -> FFFF_FFFF; read 0x00/0x04/0x08/0x10 -> 0; irq=0, tick=0.
- Prescale: PRESCALE=3, CTRL=1 -> tick every 4 cycles; after 40 cycles COUNT reads 10.
- Compare, no autoreload: COMPARE=5, CTRL=0x5, PRESCALE=0 -> match and irq rise on the tick where COUNT goes 5->6. W1C STATUS=1 -> irq drops next cycle; COUNT keeps running.
- Autoreload: COMPARE=2, CTRL=0x3 -> COUNT sequence 0,1,2,0,1,2; match sets on the first 2->0 transition.
- Wrap and simultaneous events:
  - COUNT=FFFF_FFFE, PRESCALE=0, en=1 -> after 2 ticks COUNT=0 and wrap=1.
  - W1C of wrap in the same cycle as its set -> wrap stays 1.
- Byte enables and unmapped access:
  - Write COMPARE=0xAABBCCDD with be=0b0101 over value 0 -> reads 0x00BB00DD.
  - Write to offset 0x14 -> no register changes; its read -> 0.
